// File: rtl/seq_stream_ctrl.sv
// Two-requester round-robin word-to-bitstream sequencer for the fsmseq 1011 detector.
// Optional SEQ_STATS_EN adds words-completed / total-matches statistics counters.
module seq_stream_ctrl #(
    parameter int W     = 8,
    parameter int CW    = 4,
    parameter int Z_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_data,
    output logic          req1_ready,
    output logic          x,
    input  logic          z,
    output logic          busy,
    output logic          done_valid,
    output logic          done_src,
    output logic [CW-1:0] done_count,
    output logic [15:0]   stat_words,
    output logic [15:0]   stat_matches
);

    localparam int CNTW = $clog2(W + Z_LAT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    shreg;
    logic            src;
    logic            last;
    logic [CNTW-1:0] cnt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            in_window;
    logic            last_bit;
    logic            drain_end;
    logic            grant0;
    logic            grant1;
    logic            report_entry;

    // Handshake: a word transfers on a rising edge where reqN_valid and reqN_ready
    // are both high; ready is only ever offered in IDLE, to the arbitration winner.
    assign grant0     = req0_valid && (!req1_valid || last);
    assign grant1     = req1_valid && (!req0_valid || !last);
    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;

    assign x    = (state == SHIFT) ? shreg[W-1] : 1'b0;
    assign busy = (state != IDLE);

    assign last_bit  = (cnt == CNTW'(W - 1));
    assign drain_end = (cnt == CNTW'(Z_LAT - 1));

    // z for bit i arrives Z_LAT edges after bit i was sampled.
    assign in_window = ((state == SHIFT) && (cnt >= CNTW'(Z_LAT))) || (state == DRAIN);

    always_comb begin
        count_next = count;
        if (in_window && z && (count != {CW{1'b1}}))
            count_next = count + CW'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req0_ready || req1_ready) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = (Z_LAT == 0) ? REPORT : DRAIN;
            DRAIN:   if (drain_end) state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign report_entry = (state_next == REPORT) && (state != REPORT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            src        <= 1'b0;
            last       <= 1'b1;
            cnt        <= '0;
            count      <= '0;
            done_valid <= 1'b0;
            done_src   <= 1'b0;
            done_count <= '0;
        end else begin
            state      <= state_next;
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        shreg <= req0_ready ? req0_data : req1_data;
                        src   <= req1_ready;
                        count <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    count <= count_next;
                    cnt   <= last_bit ? '0 : cnt + CNTW'(1);
                end
                DRAIN: begin
                    count <= count_next;
                    cnt   <= cnt + CNTW'(1);
                end
                REPORT: last <= src;
                default: ;
            endcase
            // The final window sample lands on this same edge, so report count_next.
            if (report_entry) begin
                done_valid <= 1'b1;
                done_src   <= src;
                done_count <= count_next;
            end
        end
    end

`ifdef SEQ_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_words   <= '0;
            stat_matches <= '0;
        end else if (report_entry) begin
            stat_words   <= stat_words + 16'd1;
            stat_matches <= stat_matches + 16'(count_next);
        end
    end
`else
    assign stat_words   = '0;
    assign stat_matches = '0;
`endif

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Directed bench for seq_stream_ctrl with a behavioural 1011 Moore detector on x/z.
// Expected stats follow SEQ_STATS_EN when it is defined for the build.
module tb_seq_stream_ctrl;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int Z_LAT = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0_valid = 1'b0;
    logic [W-1:0]  req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [W-1:0]  req1_data = '0;
    logic          req1_ready;
    logic          x;
    logic          z;
    logic          busy;
    logic          done_valid;
    logic          done_src;
    logic [CW-1:0] done_count;
    logic [15:0]   stat_words;
    logic [15:0]   stat_matches;

    int checks = 0;
    int failures = 0;
    int exp_words = 0;
    int exp_matches = 0;
    logic [4:0] exp_q[$];

    seq_stream_ctrl #(.W(W), .CW(CW), .Z_LAT(Z_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .x(x), .z(z), .busy(busy),
        .done_valid(done_valid), .done_src(done_src), .done_count(done_count),
        .stat_words(stat_words), .stat_matches(stat_matches)
    );

    always #5 clk = ~clk;

    // Non-overlapping 1011 Moore detector; z is valid one clock after x is sampled.
    typedef enum logic [2:0] {D0, D1, D2, D3, D4} det_t;
    det_t det;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) det <= D0;
        else case (det)
            D0:      det <= x ? D1 : D0;
            D1:      det <= x ? D1 : D2;
            D2:      det <= x ? D3 : D0;
            D3:      det <= x ? D4 : D2;
            default: det <= x ? D1 : D0;
        endcase
    end
    assign z = (det == D4);

    typedef struct {
        logic         src;
        logic [W-1:0] data;
        logic [CW-1:0] exp_count;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_words = 0;
        exp_matches = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One isolated word: handshake, bit stream, report timing and contents.
    task automatic run_word(input logic s, input logic [W-1:0] d, input logic [CW-1:0] ec);
        int n;
        @(negedge clk);
        if (s) begin req1_data = d; req1_valid = 1'b1; end
        else   begin req0_data = d; req0_valid = 1'b1; end
        #1;
        n = 0;
        while (!(s ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("ready_granted", s ? req1_ready : req0_ready, 1);
        check("ready_other", s ? req0_ready : req1_ready, 0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                check("busy_shift", busy, 1);
            end
            check("x_bit", x, d[W-1-i]);
        end
        @(negedge clk);
        check("x_drain", x, 0);
        check("done_early", done_valid, 0);
        @(negedge clk);
        check("done_valid", done_valid, 1);
        check("done_src", done_src, s);
        check("done_count", done_count, ec);
        exp_words++;
        exp_matches += int'(ec);
        @(negedge clk);
        check("done_pulse_width", done_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int gap;
        int seen;
        int cyc;
        int stray;
        logic [4:0] e;

        vecs[0] = '{1'b0, 8'b1011_1011, 4'd2};
        vecs[1] = '{1'b1, 8'b1100_1001, 4'd0};
        vecs[2] = '{1'b0, 8'b0000_1011, 4'd1};
        vecs[3] = '{1'b1, 8'b1011_0000, 4'd1};
        vecs[4] = '{1'b0, 8'b1111_1111, 4'd0};
        vecs[5] = '{1'b1, 8'b1010_1011, 4'd1};
        vecs[6] = '{1'b0, 8'b0101_1011, 4'd1};
        vecs[7] = '{1'b1, 8'b1011_1011, 4'd2};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_x", x, 0);
        check("rst_busy", busy, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_src", done_src, 0);
        check("rst_done_count", done_count, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_stat_words", stat_words, 0);
        check("rst_stat_matches", stat_matches, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Valid pulse withdrawn before any rising edge
        @(posedge clk);
        #1 req0_valid = 1'b1;
        req0_data = 8'b1011_1011;
        #2 req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("glitch_busy", busy, 0);
            check("glitch_x", x, 0);
            check("glitch_ready", req0_ready, 0);
        end

        for (int v = 0; v < 8; v++)
            run_word(vecs[v].src, vecs[v].data, vecs[v].exp_count);

        // Both requesters held valid: round-robin starting at req0 after reset
        do_reset();
        @(negedge clk);
        req0_data = 8'b1011_1011;
        req1_data = 8'b0101_1011;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("arb_first_ready0", req0_ready, 1);
        check("arb_first_ready1", req1_ready, 0);
        exp_q.push_back({1'b0, 4'd2});
        exp_q.push_back({1'b1, 4'd1});
        exp_q.push_back({1'b0, 4'd2});
        exp_q.push_back({1'b1, 4'd1});
        seen = 0;
        gap = 0;
        cyc = 0;
        while (seen < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            gap++;
            if (done_valid) begin
                e = exp_q.pop_front();
                check("arb_done_src", done_src, e[4]);
                check("arb_done_count", done_count, e[3:0]);
                if (seen > 0) check("arb_spacing", gap, W + Z_LAT + 2);
                exp_words++;
                exp_matches += int'(e[3:0]);
                gap = 0;
                seen++;
                if (seen == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        check("arb_done_total", seen, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("arb_idle_after", busy, 0);

        // Reset asserted while bit 3 of a word is on x
        @(negedge clk);
        req0_data = 8'b1011_1011;
        req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_x_before", x, 1);
        reset_n = 1'b0;
        exp_words = 0;
        exp_matches = 0;
        #1;
        check("midrst_x", x, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done_valid", done_valid, 0);
        check("midrst_stat_words", stat_words, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_valid || busy) stray++;
        end
        check("midrst_no_done", stray, 0);

        run_word(1'b0, 8'b1011_1011, 4'd2);
        run_word(1'b1, 8'b1100_1001, 4'd0);
        run_word(1'b0, 8'b0000_1011, 4'd1);

`ifdef SEQ_STATS_EN
        check("stat_words", stat_words, exp_words);
        check("stat_matches", stat_matches, exp_matches);
`else
        check("stat_words_off", stat_words, 0);
        check("stat_matches_off", stat_matches, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
